// File: rtl/md_unit_pkg.sv
// Shared encodings for the multiply/divide unit: md_op codes, FSM states and widths.
package md_unit_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_unit_ctrl.sv
// Sequencing for mult/div: IDLE/BUSY FSM with a down-counter that sets the fixed latency.
module md_unit_ctrl
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic accept,
   input  logic is_div,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

   md_state_e        state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // done marks the last busy cycle; the following edge commits the pending result.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n = ST_BUSY;
               cnt_n   = is_div ? DIV_N : MULT_N;
            end
         end
         ST_BUSY: begin
            cnt_n = cnt - 1'b1;
            if (cnt == 4'd1) begin
               done    = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_BUSY);

endmodule

// File: rtl/md_unit.sv
// MIPS E-stage multiply/divide unit owning HI/LO; results are staged in pending
// registers at issue and committed when the fixed-latency counter expires.
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        md_op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              flush,
   output logic              busy,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   function automatic logic [63:0] mul_s(input logic signed [31:0] x, input logic signed [31:0] y);
      logic signed [63:0] xs, ys;
      xs = {{32{x[31]}}, x};
      ys = {{32{y[31]}}, y};
      return xs * ys;
   endfunction

   function automatic logic [63:0] mul_u(input logic [31:0] x, input logic [31:0] y);
      return {32'd0, x} * {32'd0, y};
   endfunction

   // Returns {remainder, quotient}; the one overflowing case is pinned so no trap can arise.
   function automatic logic [63:0] div_s(input logic signed [31:0] x, input logic signed [31:0] y);
      logic signed [31:0] q, r;
      if (y == 32'sd0) return 64'd0;
      if (x == 32'sh8000_0000 && y == -32'sd1) return {32'd0, 32'h8000_0000};
      q = x / y;
      r = x % y;
      return {r, q};
   endfunction

   function automatic logic [63:0] div_u(input logic [31:0] x, input logic [31:0] y);
      if (y == 32'd0) return 64'd0;
      return {x % y, x / y};
   endfunction

   logic signed [DATA_W-1:0] a_s, b_s;
   logic                     is_md, is_div, is_mthi, is_mtlo;
   logic                     issue, accept_md, done;
   logic [DATA_W-1:0]        res_hi, res_lo;
   logic                     res_wr;
   logic [DATA_W-1:0]        pend_hi, pend_lo;
   logic                     pend_wr;

   assign a_s = a;
   assign b_s = b;

   always_comb begin
      is_md   = 1'b0;
      is_div  = 1'b0;
      is_mthi = 1'b0;
      is_mtlo = 1'b0;
      case (md_op)
         MD_MULT, MD_MULTU: is_md = 1'b1;
         MD_DIV, MD_DIVU: begin
            is_md  = 1'b1;
            is_div = 1'b1;
         end
         MD_MTHI: is_mthi = 1'b1;
         MD_MTLO: is_mtlo = 1'b1;
         default: ;
      endcase
   end

   assign issue     = start && !busy && !flush;
   assign accept_md = issue && is_md;

   always_comb begin
      res_hi = hi;
      res_lo = lo;
      res_wr = 1'b0;
      case (md_op)
         MD_MULT: begin
            {res_hi, res_lo} = mul_s(a_s, b_s);
            res_wr = 1'b1;
         end
         MD_MULTU: begin
            {res_hi, res_lo} = mul_u(a, b);
            res_wr = 1'b1;
         end
         MD_DIV: begin
            if (b != '0) begin
               {res_hi, res_lo} = div_s(a_s, b_s);
               res_wr = 1'b1;
            end
         end
         MD_DIVU: begin
            if (b != '0) begin
               {res_hi, res_lo} = div_u(a, b);
               res_wr = 1'b1;
            end
         end
         default: ;
      endcase
   end

   md_unit_ctrl #(
      .MULT_CYCLES(MULT_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_ctrl (
      .clk   (clk),
      .reset (reset),
      .accept(accept_md),
      .is_div(is_div),
      .busy  (busy),
      .done  (done)
   );

   // Issue stage captures the result; commit stage moves it into HI/LO on done.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_wr <= 1'b0;
      end else begin
         if (accept_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
         end
         if (done && pend_wr) begin
            hi <= pend_hi;
            lo <= pend_lo;
         end
         if (issue && is_mthi) hi <= a;
         if (issue && is_mtlo) lo <= a;
      end
   end

endmodule
